unidad_control_mc: RTL
======================

Name: unidad_control_mc

Overview:
- Multicycle control unit that sequences the microc datapath.
- Replaces the free-running single-cycle control: fetches each instruction under a memory-ready handshake, then drives s_inc/s_inm/we3/wez/Op for exactly one execute cycle.
- Supports run, single-step and halt, and keeps a retired-instruction counter.
- Sits beside microc. Opcode and z come from microc; all control outputs plus pc_we and ir_we go back to microc.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.
- TIMEOUT, 15, maximum FETCH wait cycles; used only when WAIT_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  one-cycle pulse; starts or resumes execution.
- step_en  in  1  1 = single-step mode.
- step  in  1  one-cycle pulse; executes one instruction while in PAUSE.
- mem_ready  in  1  instruction memory has valid Opcode this cycle.
- Opcode  in  6  instruction opcode from microc.
- z  in  1  zero flag from microc.
- s_inc  out  1  PC mux: 1 = PC+1, 0 = jump target.
- s_inm  out  1  register-file write-data mux: 1 = immediate.
- we3  out  1  register-file write enable.
- wez  out  1  zero-flag write enable.
- Op  out  3  ALU operation.
- pc_we  out  1  PC load enable.
- ir_we  out  1  instruction-register capture enable.
- busy  out  1  1 in FETCH or EXEC.
- halted  out  1  1 in HALT.
- illegal  out  1  sticky undefined-opcode flag.
- retired  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE; internal ir is cleared to 0.
  - Every output is 0, including the counter, illegal and halted.
- States: IDLE, FETCH, EXEC, PAUSE, HALT.
- IDLE:
  - start=1 -> FETCH. Otherwise stay.
  - step is ignored.
- FETCH:
  - ir_we is asserted for exactly the cycles where mem_ready=1.
  - mem_ready=1 -> Opcode latched into internal ir; next state EXEC.
  - mem_ready=0 -> stay in FETCH.
- EXEC (one cycle): pc_we=1; decode from ir with z sampled live.
  - 1xxxxx ALU: s_inc=1, we3=1, wez=1, Op=ir[4:2].
  - 000000 nop: s_inc=1.
  - 0001xx li: s_inc=1, s_inm=1, we3=1.
  - 010000 j: s_inc=0.
  - 010001 jz: s_inc=~z.
  - 010010 jnz: s_inc=z.
  - 011111 halt: pc_we=0, all controls 0, next state HALT, not counted.
  - Any other opcode: behaves as nop and sets illegal=1 until reset.
- Retired counter: increments at the end of each non-halt EXEC and wraps modulo 2^CNT_W.
- Next state after a non-halt EXEC:
  - step_en=1 -> PAUSE.
  - step_en=0 -> FETCH.
- PAUSE:
  - step=1 or start=1 -> FETCH.
  - step_en cleared while in PAUSE -> FETCH next cycle.
- HALT:
  - start=1 -> FETCH. The PC was not advanced, so the controller re-fetches the halt instruction.
  - step is ignored.
- Default values: in every state other than EXEC, s_inc, s_inm, we3, wez, Op and pc_we are 0.
- Latency:
  - start -> first EXEC: 2 cycles with mem_ready held at 1.
  - Steady-state throughput: 1 instruction per 2 cycles.
- start arriving in FETCH or EXEC is ignored.
- Outputs: the control outputs are combinational from state/ir/z; busy, halted and illegal are registered.

Optional Feature:
- Macro: WAIT_TIMEOUT_EN.
- When defined:
  - A counter runs during FETCH and clears whenever FETCH is entered.
  - If it reaches TIMEOUT with mem_ready still 0, the block goes to HALT and asserts output timeout_err.
  - timeout_err is sticky until reset.
  - start from HALT clears timeout_err.
- When undefined:
  - FETCH waits indefinitely.
  - The timeout_err port is absent.

Test Plan:
- Reset then start, mem_ready=1, Opcode=100100 -> EXEC 2 cycles after start with s_inc=1, we3=1, wez=1, Op=001; retired=1.
- Opcode=010001 with z=1 -> s_inc=0, pc_we=1. Same opcode with z=0 -> s_inc=1.
- mem_ready held 0 for 5 cycles in FETCH -> state stays FETCH, ir_we=0, all controls 0. mem_ready=1 -> EXEC on the next cycle.
- step_en=1, run 3 step pulses with Opcode=000100 -> 3 EXEC cycles with s_inm=1, we3=1, then PAUSE; retired=3.
- Opcode=011111 -> halted=1, retired unchanged. Opcode=001000 -> illegal=1, s_inc=1, retired incremented.
- Drive reset=0 mid-EXEC -> all outputs 0 immediately. With WAIT_TIMEOUT_EN defined and mem_ready=0 for 15 cycles -> halted=1, timeout_err=1.

Source files
------------

// File: rtl/unidad_control_mc_if.sv
// Control bus between unidad_control_mc and the microc datapath.
// master = control unit side, slave = datapath / memory side.
interface unidad_control_mc_if;
  localparam int unsigned OPC_W = 6;
  localparam int unsigned OP_W  = 3;

  logic             mem_ready;
  logic [OPC_W-1:0] Opcode;
  logic             z;
  logic             s_inc;
  logic             s_inm;
  logic             we3;
  logic             wez;
  logic [OP_W-1:0]  Op;
  logic             pc_we;
  logic             ir_we;

  modport master (
    input  mem_ready, Opcode, z,
    output s_inc, s_inm, we3, wez, Op, pc_we, ir_we
  );

  modport slave (
    output mem_ready, Opcode, z,
    input  s_inc, s_inm, we3, wez, Op, pc_we, ir_we
  );
endinterface

// File: rtl/unidad_control_mc.sv
// Multicycle control unit for the microc datapath.
// Fetches one opcode per instruction under a mem_ready handshake, then drives
// the datapath controls for a single execute cycle. Supports run, single-step
// and halt, and counts retired instructions.
// Optional build macro WAIT_TIMEOUT_EN: bounds the FETCH wait to TIMEOUT cycles,
// then halts and raises the sticky timeout_err output.
module unidad_control_mc #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     step_en,
  input  logic                     step,
  unidad_control_mc_if.master      bus,
  output logic                     busy,
  output logic                     halted,
  output logic                     illegal,
  output logic [CNT_W-1:0]         retired
`ifdef WAIT_TIMEOUT_EN
  ,
  output logic                     timeout_err
`endif
);

  localparam int unsigned OPC_W = 6;
  localparam int unsigned OP_W  = 3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_PAUSE = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  // A zero timeout would make the FETCH bound meaningless.
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  state_t           state_q;
  state_t           state_d;
  logic [OPC_W-1:0] ir_q;

  logic             s_inc_c;
  logic             s_inm_c;
  logic             we3_c;
  logic             wez_c;
  logic [OP_W-1:0]  op_c;
  logic             pc_we_c;
  logic             ir_we_c;
  logic             is_halt_c;
  logic             is_illegal_c;
  logic             timeout_hit_c;

`ifdef WAIT_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TO_W-1:0] wait_q;

  // Last permitted wait cycle has been reached with no ready memory.
  assign timeout_hit_c = (state_q == S_FETCH) && !bus.mem_ready &&
                         (wait_q == TO_W'(TIMEOUT - 1));
`else
  assign timeout_hit_c = 1'b0;
`endif

  // Execute-cycle decode from the captured opcode; z is used live.
  always_comb begin
    s_inc_c      = 1'b0;
    s_inm_c      = 1'b0;
    we3_c        = 1'b0;
    wez_c        = 1'b0;
    op_c         = '0;
    pc_we_c      = 1'b0;
    is_halt_c    = 1'b0;
    is_illegal_c = 1'b0;
    if (state_q == S_EXEC) begin
      pc_we_c = 1'b1;
      casez (ir_q)
        6'b1?????: begin
          s_inc_c = 1'b1;
          we3_c   = 1'b1;
          wez_c   = 1'b1;
          op_c    = ir_q[4:2];
        end
        6'b000000: s_inc_c = 1'b1;
        6'b0001??: begin
          s_inc_c = 1'b1;
          s_inm_c = 1'b1;
          we3_c   = 1'b1;
        end
        6'b010000: s_inc_c = 1'b0;
        6'b010001: s_inc_c = ~bus.z;
        6'b010010: s_inc_c = bus.z;
        6'b011111: begin
          pc_we_c   = 1'b0;
          is_halt_c = 1'b1;
        end
        default: begin
          s_inc_c      = 1'b1;
          is_illegal_c = 1'b1;
        end
      endcase
    end
  end

  // Next-state logic and instruction-register capture enable.
  always_comb begin
    state_d = state_q;
    ir_we_c = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (bus.mem_ready) begin
          ir_we_c = 1'b1;
          state_d = S_EXEC;
        end else if (timeout_hit_c) begin
          state_d = S_HALT;
        end
      end
      S_EXEC: begin
        if (is_halt_c)    state_d = S_HALT;
        else if (step_en) state_d = S_PAUSE;
        else              state_d = S_FETCH;
      end
      S_PAUSE: begin
        if (step || start || !step_en) state_d = S_FETCH;
      end
      S_HALT: begin
        if (start) state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Instruction register, loaded on each accepted fetch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       ir_q <= '0;
    else if (ir_we_c) ir_q <= bus.Opcode;
  end

  // Registered status flags track the state being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy    <= 1'b0;
      halted  <= 1'b0;
      illegal <= 1'b0;
    end else begin
      busy   <= (state_d == S_FETCH) || (state_d == S_EXEC);
      halted <= (state_d == S_HALT);
      if (is_illegal_c) illegal <= 1'b1;
    end
  end

  // Retired-instruction counter; halt does not retire.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                               retired <= '0;
    else if (state_q == S_EXEC && !is_halt_c) retired <= retired + CNT_W'(1);
  end

`ifdef WAIT_TIMEOUT_EN
  // FETCH wait counter; cleared outside FETCH so each entry starts at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                   wait_q <= '0;
    else if (state_q != S_FETCH)  wait_q <= '0;
    else if (!bus.mem_ready)      wait_q <= wait_q + TO_W'(1);
  end

  // Sticky timeout flag; a restart from HALT clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                           timeout_err <= 1'b0;
    else if (timeout_hit_c)               timeout_err <= 1'b1;
    else if (state_q == S_HALT && start)  timeout_err <= 1'b0;
  end
`endif

  assign bus.s_inc = s_inc_c;
  assign bus.s_inm = s_inm_c;
  assign bus.we3   = we3_c;
  assign bus.wez   = wez_c;
  assign bus.Op    = op_c;
  assign bus.pc_we = pc_we_c;
  assign bus.ir_we = ir_we_c;

endmodule
